mvau_seq_ctrl: RTL and testbench



---
 rtl/mvau_seq_pkg.sv | 17 +
 rtl/mvau_seq_wrap_cnt.sv | 26 ++
 rtl/mvau_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mvau_seq_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvau_seq_pkg.sv
// Shared types and helpers for the MVAU lane sequencer.
// Optional statistics counters are enabled with MVAU_SEQ_STATS_EN.
package mvau_seq_pkg;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_REUSE = 1'b1
    } seq_state_t;

    localparam int STAT_W = 32;

    // Counter width that never collapses to zero bits.
    function automatic int cw(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvau_seq_wrap_cnt.sv
// Modulo-MAX up-counter; wrap pulses on the enabled step that returns to zero.
module mvau_seq_wrap_cnt #(
    parameter int MAX = 2,
    parameter int W   = 1
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic at_max;

    assign at_max = (cnt == W'(MAX - 1));
    assign wrap   = en && at_max;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_max ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mvau_seq_ctrl.sv
// Sequencer for one MVAU compute lane: fills the input buffer on bank 0, replays it
// for later banks, and drives memory addresses, accumulator control and result valid.
// Define MVAU_SEQ_STATS_EN to add the stall_cnt/row_cnt statistics ports.
module mvau_seq_ctrl
    import mvau_seq_pkg::*;
#(
    parameter int SF           = 8,
    parameter int NF           = 8,
    parameter int WMEM_DEPTH   = SF * NF,
    parameter int SF_T         = cw(SF),
    parameter int NF_T         = cw(NF),
    parameter int WMEM_ADDR_BW = cw(WMEM_DEPTH)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    in_v,
    output logic                    in_rdy,
    output logic                    ibuf_wen,
    output logic                    ibuf_ren,
    output logic [SF_T-1:0]         ibuf_addr,
    output logic                    wmem_ren,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic                    acc_en,
    output logic                    acc_clr,
    output logic                    acc_last,
    output logic                    out_v,
    input  logic                    out_rdy
`ifdef MVAU_SEQ_STATS_EN
    ,
    output logic [STAT_W-1:0]       stall_cnt,
    output logic [STAT_W-1:0]       row_cnt
`endif
);

    seq_state_t state;
    seq_state_t state_nxt;

    logic [SF_T-1:0]         sf_cnt;
    logic [NF_T-1:0]         nf_cnt;
    logic [WMEM_ADDR_BW-1:0] wmem_cnt;
    logic                    sf_wrap;
    logic                    nf_wrap;
    logic                    wmem_wrap;

    logic is_last;
    logic out_hs;
    logic blk;
    logic fire;
    logic out_pend;

    assign is_last = (sf_cnt == SF_T'(SF - 1));
    assign out_hs  = out_v && out_rdy;
    // Only a row's final beat can be held: it would overwrite the unread result.
    assign blk     = is_last && out_pend && !out_hs;
    assign in_rdy  = (state == S_FILL) && !blk;
    assign fire    = (state == S_FILL) ? (in_v && in_rdy) : !blk;

    assign ibuf_wen  = fire && (state == S_FILL);
    assign ibuf_ren  = fire && (state == S_REUSE);
    assign ibuf_addr = sf_cnt;
    assign wmem_ren  = fire;
    assign wmem_addr = wmem_cnt;

    mvau_seq_wrap_cnt #(.MAX(SF), .W(SF_T)) u_sf_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .en      (fire),
        .cnt     (sf_cnt),
        .wrap    (sf_wrap)
    );

    mvau_seq_wrap_cnt #(.MAX(NF), .W(NF_T)) u_nf_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .en      (sf_wrap),
        .cnt     (nf_cnt),
        .wrap    (nf_wrap)
    );

    mvau_seq_wrap_cnt #(.MAX(WMEM_DEPTH), .W(WMEM_ADDR_BW)) u_wmem_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .en      (fire),
        .cnt     (wmem_cnt),
        .wrap    (wmem_wrap)
    );

    // The bank index and the weight wrap are implied by state and nf_wrap.
    logic unused_cnt_bits;
    assign unused_cnt_bits = &{1'b0, nf_cnt, wmem_wrap};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL: begin
                if (sf_wrap && (NF > 1)) begin
                    state_nxt = S_REUSE;
                end
            end
            S_REUSE: begin
                if (nf_wrap) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // Accumulator controls lag fire by one cycle to line up with synchronous memory data.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc_en   <= 1'b0;
            acc_clr  <= 1'b0;
            acc_last <= 1'b0;
        end else begin
            acc_en   <= fire;
            acc_clr  <= fire && (sf_cnt == '0);
            acc_last <= fire && is_last;
        end
    end

    // out_pend tracks a result from its last beat until it is taken downstream.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_pend <= 1'b0;
        end else if (fire && is_last) begin
            out_pend <= 1'b1;
        end else if (out_hs) begin
            out_pend <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_v <= 1'b0;
        end else if (acc_last) begin
            out_v <= 1'b1;
        end else if (out_hs) begin
            out_v <= 1'b0;
        end
    end

`ifdef MVAU_SEQ_STATS_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stall_cnt <= '0;
            row_cnt   <= '0;
        end else begin
            if (blk && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (out_hs && (row_cnt != '1)) begin
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mvau_seq_ctrl.sv
// Directed bench for mvau_seq_ctrl: an SF=4/NF=2 lane and an SF=1/NF=1 lane.
// Statistics checks are included when MVAU_SEQ_STATS_EN is defined.
module tb_mvau_seq_ctrl;

    logic aclk;
    logic aresetn;

    logic       a_in_v, a_in_rdy, a_ibuf_wen, a_ibuf_ren, a_wmem_ren;
    logic [1:0] a_ibuf_addr;
    logic [2:0] a_wmem_addr;
    logic       a_acc_en, a_acc_clr, a_acc_last, a_out_v, a_out_rdy;

    logic       b_in_v, b_in_rdy, b_ibuf_wen, b_ibuf_ren, b_wmem_ren;
    logic [0:0] b_ibuf_addr;
    logic [0:0] b_wmem_addr;
    logic       b_acc_en, b_acc_clr, b_acc_last, b_out_v, b_out_rdy;

`ifdef MVAU_SEQ_STATS_EN
    logic [31:0] a_stall_cnt, a_row_cnt, b_stall_cnt, b_row_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mvau_seq_ctrl #(.SF(4), .NF(2)) u_a (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_v      (a_in_v),
        .in_rdy    (a_in_rdy),
        .ibuf_wen  (a_ibuf_wen),
        .ibuf_ren  (a_ibuf_ren),
        .ibuf_addr (a_ibuf_addr),
        .wmem_ren  (a_wmem_ren),
        .wmem_addr (a_wmem_addr),
        .acc_en    (a_acc_en),
        .acc_clr   (a_acc_clr),
        .acc_last  (a_acc_last),
        .out_v     (a_out_v),
        .out_rdy   (a_out_rdy)
`ifdef MVAU_SEQ_STATS_EN
        ,
        .stall_cnt (a_stall_cnt),
        .row_cnt   (a_row_cnt)
`endif
    );

    mvau_seq_ctrl #(.SF(1), .NF(1)) u_b (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_v      (b_in_v),
        .in_rdy    (b_in_rdy),
        .ibuf_wen  (b_ibuf_wen),
        .ibuf_ren  (b_ibuf_ren),
        .ibuf_addr (b_ibuf_addr),
        .wmem_ren  (b_wmem_ren),
        .wmem_addr (b_wmem_addr),
        .acc_en    (b_acc_en),
        .acc_clr   (b_acc_clr),
        .acc_last  (b_acc_last),
        .out_v     (b_out_v),
        .out_rdy   (b_out_rdy)
`ifdef MVAU_SEQ_STATS_EN
        ,
        .stall_cnt (b_stall_cnt),
        .row_cnt   (b_row_cnt)
`endif
    );

    // Clock and reset
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Leaves the bench in cycle 0: the first cycle with aresetn high after reset.
    task automatic reset_dut();
        aresetn   = 1'b0;
        a_in_v    = 1'b0;
        a_out_rdy = 1'b0;
        b_in_v    = 1'b0;
        b_out_rdy = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        reset_dut();
        settle();
        n_checks++;
        if (a_in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset in_rdy got=%0b exp=1", a_in_rdy);
        end
        n_checks++;
        if ({a_out_v, a_acc_en, a_acc_clr, a_acc_last} !== 4'b0000) begin
            n_fail++; $display("FAIL reset out_v/acc got=%b exp=0000",
                               {a_out_v, a_acc_en, a_acc_clr, a_acc_last});
        end
        n_checks++;
        if ({a_wmem_addr, a_ibuf_addr} !== 5'd0) begin
            n_fail++; $display("FAIL reset addr got=%0d/%0d exp=0/0", a_wmem_addr, a_ibuf_addr);
        end
        n_checks++;
        if ({b_in_rdy, b_out_v} !== 2'b10) begin
            n_fail++; $display("FAIL reset b in_rdy/out_v got=%b exp=10", {b_in_rdy, b_out_v});
        end
`ifdef MVAU_SEQ_STATS_EN
        n_checks++;
        if ({a_stall_cnt, a_row_cnt} !== 64'd0) begin
            n_fail++; $display("FAIL reset stats got=%0d/%0d exp=0/0", a_stall_cnt, a_row_cnt);
        end
`endif
    endtask

    task automatic test_full_flow();
        logic exp_rdy, exp_clr, exp_last, exp_ov, exp_wen, exp_ren;
        reset_dut();
        a_in_v    = 1'b1;
        a_out_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            settle();
            exp_rdy  = (c <= 3) || (c >= 8);
            exp_clr  = (c == 1) || (c == 5) || (c == 9);
            exp_last = (c == 4) || (c == 8);
            exp_ov   = (c == 5) || (c == 9);
            exp_wen  = (c <= 3) || (c >= 8);
            exp_ren  = (c >= 4) && (c <= 7);
            n_checks++;
            if (a_in_rdy !== exp_rdy) begin
                n_fail++; $display("FAIL full_flow in_rdy c=%0d got=%0b exp=%0b", c, a_in_rdy, exp_rdy);
            end
            n_checks++;
            if ({a_acc_clr, a_acc_last, a_out_v} !== {exp_clr, exp_last, exp_ov}) begin
                n_fail++; $display("FAIL full_flow clr/last/out_v c=%0d got=%b exp=%b", c,
                                   {a_acc_clr, a_acc_last, a_out_v}, {exp_clr, exp_last, exp_ov});
            end
            n_checks++;
            if ({a_ibuf_wen, a_ibuf_ren, a_wmem_ren, a_acc_en} !== {exp_wen, exp_ren, 1'b1, c >= 1}) begin
                n_fail++; $display("FAIL full_flow enables c=%0d got=%b exp=%b", c,
                                   {a_ibuf_wen, a_ibuf_ren, a_wmem_ren, a_acc_en},
                                   {exp_wen, exp_ren, 1'b1, c >= 1});
            end
            if (c < 8) begin
                n_checks++;
                if (int'(a_wmem_addr) !== c || int'(a_ibuf_addr) !== c % 4) begin
                    n_fail++; $display("FAIL full_flow addr c=%0d got=%0d/%0d exp=%0d/%0d",
                                       c, a_wmem_addr, a_ibuf_addr, c, c % 4);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int   exp_wa;
        logic exp_ren, exp_rdy, exp_ov;
        reset_dut();
        a_in_v    = 1'b1;
        a_out_rdy = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) tick();
            if (c == 20) a_out_rdy = 1'b1;
            settle();
            exp_wa  = (c <= 7) ? c : ((c <= 20) ? 7 : c - 21);
            exp_ren = !((c >= 7) && (c <= 19));
            exp_rdy = (c <= 3) || (c >= 21);
            exp_ov  = ((c >= 5) && (c <= 20)) || (c == 22);
            n_checks++;
            if (int'(a_wmem_addr) !== exp_wa) begin
                n_fail++; $display("FAIL backpressure wmem_addr c=%0d got=%0d exp=%0d", c, a_wmem_addr, exp_wa);
            end
            n_checks++;
            if ({a_wmem_ren, a_in_rdy, a_out_v} !== {exp_ren, exp_rdy, exp_ov}) begin
                n_fail++; $display("FAIL backpressure ren/rdy/out_v c=%0d got=%b exp=%b", c,
                                   {a_wmem_ren, a_in_rdy, a_out_v}, {exp_ren, exp_rdy, exp_ov});
            end
            n_checks++;
            if (a_acc_last !== ((c == 4) || (c == 21))) begin
                n_fail++; $display("FAIL backpressure acc_last c=%0d got=%0b exp=%0b", c, a_acc_last,
                                   (c == 4) || (c == 21));
            end
`ifdef MVAU_SEQ_STATS_EN
            if (c == 20) begin
                n_checks++;
                if (a_stall_cnt !== 32'd13) begin
                    n_fail++; $display("FAIL stats stall_cnt got=%0d exp=13", a_stall_cnt);
                end
            end
            if (c == 23) begin
                n_checks++;
                if (a_row_cnt !== 32'd2 || a_stall_cnt !== 32'd13) begin
                    n_fail++; $display("FAIL stats row/stall got=%0d/%0d exp=2/13", a_row_cnt, a_stall_cnt);
                end
            end
`endif
        end
    endtask

    task automatic test_single_beat();
        int accepted = 0;
        int taken    = 0;
        reset_dut();
        b_in_v = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) tick();
            b_out_rdy = (c % 2 == 0);
            settle();
            n_checks++;
            if ({b_in_rdy, b_out_v} !== {c % 2 == 0, (c >= 2) && (c % 2 == 0)}) begin
                n_fail++; $display("FAIL single_beat rdy/out_v c=%0d got=%b exp=%b", c,
                                   {b_in_rdy, b_out_v}, {c % 2 == 0, (c >= 2) && (c % 2 == 0)});
            end
            n_checks++;
            if ((b_acc_last && b_out_v && !b_out_rdy) !== 1'b0) begin
                n_fail++; $display("FAIL single_beat overwrite c=%0d got=1 exp=0", c);
            end
            if (c == 1) begin
                n_checks++;
                if ({b_acc_en, b_acc_clr, b_acc_last} !== 3'b111) begin
                    n_fail++; $display("FAIL single_beat clr_last got=%b exp=111",
                                       {b_acc_en, b_acc_clr, b_acc_last});
                end
            end
            if (b_in_v && b_in_rdy) accepted++;
            if (b_out_v && b_out_rdy) taken++;
        end
        n_checks++;
        if (accepted !== 8 || taken !== 7) begin
            n_fail++; $display("FAIL single_beat counts got=%0d/%0d exp=8/7", accepted, taken);
        end
    endtask

    task automatic test_in_gaps();
        int pat[7]    = '{1, 0, 0, 1, 1, 0, 1};
        int exp_wa[8] = '{0, 1, 1, 1, 2, 3, 3, 4};
        logic exp_wen;
        reset_dut();
        a_out_rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            a_in_v = (c < 7) ? (pat[c] != 0) : 1'b0;
            settle();
            exp_wen = (c < 7) && (pat[c] != 0);
            n_checks++;
            if (int'(a_wmem_addr) !== exp_wa[c] || int'(a_ibuf_addr) !== exp_wa[c] % 4) begin
                n_fail++; $display("FAIL in_gaps addr c=%0d got=%0d/%0d exp=%0d/%0d", c,
                                   a_wmem_addr, a_ibuf_addr, exp_wa[c], exp_wa[c] % 4);
            end
            n_checks++;
            if (a_ibuf_wen !== exp_wen) begin
                n_fail++; $display("FAIL in_gaps ibuf_wen c=%0d got=%0b exp=%0b", c, a_ibuf_wen, exp_wen);
            end
        end
        n_checks++;
        if ({a_in_rdy, a_wmem_ren, a_ibuf_ren, a_acc_last} !== 4'b0111) begin
            n_fail++; $display("FAIL in_gaps reuse_entry got=%b exp=0111",
                               {a_in_rdy, a_wmem_ren, a_ibuf_ren, a_acc_last});
        end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        a_in_v    = 1'b1;
        a_out_rdy = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) tick();
            settle();
        end
        n_checks++;
        if ({a_out_v, a_acc_en, a_ibuf_addr} !== {1'b1, 1'b1, 2'd2}) begin
            n_fail++; $display("FAIL mid_reset pre got=%b exp=1110", {a_out_v, a_acc_en, a_ibuf_addr});
        end
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        settle();
        n_checks++;
        if ({a_wmem_addr, a_ibuf_addr} !== 5'd0 || a_in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset addr/rdy got=%0d/%0d/%0b exp=0/0/1",
                               a_wmem_addr, a_ibuf_addr, a_in_rdy);
        end
        n_checks++;
        if ({a_out_v, a_acc_en, a_acc_clr, a_acc_last} !== 4'b0000) begin
            n_fail++; $display("FAIL mid_reset out_v/acc got=%b exp=0000",
                               {a_out_v, a_acc_en, a_acc_clr, a_acc_last});
        end
        tick();
        settle();
        n_checks++;
        if (a_wmem_addr !== 3'd1 || a_ibuf_addr !== 2'd1 || a_acc_clr !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset restart got=%0d/%0d/%0b exp=1/1/1",
                               a_wmem_addr, a_ibuf_addr, a_acc_clr);
        end
    endtask

    initial begin
        test_reset();
        test_full_flow();
        test_backpressure();
        test_single_beat();
        test_in_gaps();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
